note_lane_renderer: RTL

Pixel source for the 4-lane rhythm display. Holds up to four falling notes per lane and advances them once per video frame. Judges key presses against a hit line and keeps hit/miss counts. For each pixel address requested by the VGA timing controller it returns the 12-bit colour, so it sits directly upstream of `vgac`'s `d_in`.

---
 rtl/note_lane_renderer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/note_lane_renderer.sv
// Four-lane falling-note engine: note storage, per-frame advance, key judgement
// against the hit line, and per-pixel colour generation feeding the VGA controller.
module note_lane_renderer #(
  parameter int unsigned LANE_X0 = 192,
  parameter int unsigned LANE_W  = 64,
  parameter int unsigned NOTE_H  = 16,
  parameter int unsigned HIT_Y   = 440,
  parameter int unsigned HIT_WIN = 12,
  parameter int unsigned SPEED   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        rdn,
  input  logic        vs,
  input  logic [3:0]  key,
  input  logic        spawn_valid,
  input  logic [1:0]  spawn_lane,
  output logic        spawn_ready,
  output logic [11:0] d_out,
  output logic        hit,
  output logic        miss,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);
  localparam int unsigned WIN_LO = HIT_Y - HIT_WIN;
  localparam int unsigned WIN_HI = HIT_Y + HIT_WIN;

  localparam logic [11:0] C_NOTE   = 12'h0FF;
  localparam logic [11:0] C_LINE   = 12'hFFF;
  localparam logic [11:0] C_BORDER = 12'h444;
  localparam logic [11:0] C_FLASH  = 12'h400;

  // Slot index is {lane, slot}.
  logic [15:0] r_v;
  logic [9:0]  r_y [16];
  logic [15:0] w_v_n;
  logic [9:0]  w_y_n [16];

  logic        r_vs_d;
  logic [3:0]  r_s1, r_s2, r_s3;
  logic [3:0]  r_press;
  logic        w_tick;

  logic [11:0] r_d;
  logic        r_hit, r_miss;
  logic [15:0] r_hcnt, r_mcnt;

  logic        w_ready;
  logic [1:0]  w_free;

  logic        w_found;
  logic [3:0]  w_k;
  logic [9:0]  w_ynew;
  logic [2:0]  w_nhit;
  logic [4:0]  w_nmiss;
  logic [16:0] w_hsum, w_msum;

  logic        w_in_lane;
  logic [1:0]  w_lane;
  logic [3:0]  w_rk;
  logic        w_note;
  logic        w_border;
  logic [11:0] w_pix;

  assign w_tick      = r_vs_d & ~vs;
  assign spawn_ready = w_ready;
  assign d_out       = r_d;
  assign hit         = r_hit;
  assign miss        = r_miss;
  assign hit_cnt     = r_hcnt;
  assign miss_cnt    = r_mcnt;

  always_comb begin
    w_ready = 1'b0;
    w_free  = '0;
    for (int unsigned s = 0; s < 4; s++) begin
      if (!w_ready && !r_v[{spawn_lane, 2'(s)}]) begin
        w_ready = 1'b1;
        w_free  = 2'(s);
      end
    end
  end

  // A judged slot is cleared in place and skips the frame advance; spawn only
  // targets a currently free slot, so it never collides with either path.
  always_comb begin
    w_v_n   = r_v;
    w_y_n   = r_y;
    w_nhit  = '0;
    w_nmiss = '0;
    w_found = 1'b0;
    w_k     = '0;
    w_ynew  = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      w_found = 1'b0;
      for (int unsigned s = 0; s < 4; s++) begin
        w_k    = 4'(l * 4 + s);
        w_ynew = r_y[w_k] + 10'(SPEED);
        if (r_press[2'(l)] && !w_found && r_v[w_k] &&
            32'(r_y[w_k]) >= WIN_LO && 32'(r_y[w_k]) <= WIN_HI) begin
          w_found    = 1'b1;
          w_v_n[w_k] = 1'b0;
        end else if (w_tick && r_v[w_k]) begin
          w_y_n[w_k] = w_ynew;
          if (32'(w_ynew) > WIN_HI) begin
            w_v_n[w_k] = 1'b0;
            w_nmiss    = w_nmiss + 5'd1;
          end
        end
      end
      if (w_found) w_nhit = w_nhit + 3'd1;
    end
    if (spawn_valid && w_ready) begin
      w_v_n[{spawn_lane, w_free}] = 1'b1;
      w_y_n[{spawn_lane, w_free}] = '0;
    end
  end

  assign w_hsum = {1'b0, r_hcnt} + {14'd0, w_nhit};
  assign w_msum = {1'b0, r_mcnt} + {12'd0, w_nmiss};

  always_comb begin
    w_in_lane = 1'b0;
    w_lane    = '0;
    w_note    = 1'b0;
    w_rk      = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      if (32'(col_addr) >= LANE_X0 + l * LANE_W &&
          32'(col_addr) <  LANE_X0 + (l + 1) * LANE_W) begin
        w_in_lane = 1'b1;
        w_lane    = 2'(l);
      end
    end
    for (int unsigned s = 0; s < 4; s++) begin
      w_rk = {w_lane, 2'(s)};
      if (r_v[w_rk] && 32'(row_addr) >= 32'(r_y[w_rk]) &&
          32'(row_addr) < 32'(r_y[w_rk]) + NOTE_H)
        w_note = 1'b1;
    end
    w_border = (32'(col_addr) == LANE_X0 + 32'(w_lane) * LANE_W);
    if (rdn || !w_in_lane)               w_pix = '0;
    else if (w_note)                     w_pix = C_NOTE;
    else if (32'(row_addr) == HIT_Y)     w_pix = C_LINE;
    else if (w_border)                   w_pix = C_BORDER;
    else if (r_s2[w_lane])               w_pix = C_FLASH;
    else                                 w_pix = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_d  <= 1'b1;
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_press <= '0;
      r_v     <= '0;
      r_y     <= '{default: '0};
      r_d     <= '0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
      r_hcnt  <= '0;
      r_mcnt  <= '0;
    end else begin
      r_vs_d  <= vs;
      r_s1    <= key;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_press <= r_s2 & ~r_s3;
      r_v     <= w_v_n;
      r_y     <= w_y_n;
      if (pix_en) r_d <= w_pix;
      r_hit   <= (w_nhit != '0);
      r_miss  <= (w_nmiss != '0);
      r_hcnt  <= w_hsum[16] ? 16'hFFFF : w_hsum[15:0];
      r_mcnt  <= w_msum[16] ? 16'hFFFF : w_msum[15:0];
    end
  end

endmodule
